// File: rtl/spi_control_in_pkg.sv
// Shared definitions for the SPI control input receiver.
// Contents:
//   DEFAULT_FRAME_BITS - default number of bits in one SPI frame
//   BIT_CNT_W          - width of the saturating received-bit counter
//   BIT_CNT_MAX        - saturation value of the bit counter
//   state_t            - receiver FSM state encoding (2 bits)
package spi_control_in_pkg;

  localparam int DEFAULT_FRAME_BITS = 24;
  localparam int BIT_CNT_W = 6;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECEIVE   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_control_in_sync_edge_detect.sv
// Synchronizer chain with registered rise/fall pulses for one asynchronous
// input that idles high.
// Ports:
//   i_clock  - system clock, rising edge
//   i_reset  - synchronous active-high reset, forces idle (high) levels
//   i_async  - asynchronous input signal
//   o_sync   - last synchronizer stage
//   o_rise   - one-cycle pulse, registered, after o_sync goes 0 -> 1
//   o_fall   - one-cycle pulse, registered, after o_sync goes 1 -> 0
module sync_edge_detect
  import spi_control_in_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_delay;
  logic              r_rise;
  logic              r_fall;

  // Shift the raw input through the synchronizer, keep one extra copy of the
  // last stage, and compare the two to produce registered edge pulses. Reset
  // loads the idle-high level everywhere so no edge is seen on release.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_chain <= '1;
      r_delay <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_chain[0] <= i_async;
      for (int k = 1; k < STAGES; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
      r_delay <= r_chain[STAGES-1];
      r_rise  <= r_chain[STAGES-1] & ~r_delay;
      r_fall  <= ~r_chain[STAGES-1] & r_delay;
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_control_in.sv
// SPI slave receiver (mode with clock idling high, data sampled on the SPI
// clock falling edge, MSB first) fully synchronous to i_clock.
// Ports:
//   i_clock       - system clock, rising edge
//   i_reset       - synchronous active-high reset
//   i_SPI_CS      - active-low chip select, asynchronous
//   i_SPI_clock   - SPI clock, idles high, asynchronous
//   i_SPI_data    - SPI serial data, asynchronous
//   o_data        - last correctly sized frame, first received bit in MSB
//   o_data_valid  - one-cycle pulse when o_data updates
//   o_frame_error - one-cycle pulse when a frame ends with a wrong bit count
module spi_control_in
  import spi_control_in_pkg::*;
#(
  parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_SPI_CS,
  input  logic                  i_SPI_clock,
  input  logic                  i_SPI_data,
  output logic [FRAME_BITS-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_frame_error
);

  localparam logic [BIT_CNT_W-1:0] FRAME_CNT     = BIT_CNT_W'(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] SETTLE_CYCLES = BIT_CNT_W'(SYNC_STAGES + 2);

  logic w_csSync;
  logic w_csRise;
  logic w_csFall;
  logic w_clkSync;
  logic w_clkRise;
  logic w_clkFall;
  logic w_dataSync;
  logic w_unusedClk;

  logic [SYNC_STAGES-1:0] r_dataSync;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [FRAME_BITS-1:0]  r_data;
  logic [BIT_CNT_W-1:0]   r_bitCnt;
  logic [BIT_CNT_W-1:0]   r_settle;
  logic                   r_dataValid;
  logic                   r_frameError;
  logic                   w_settled;

  state_t r_state;
  state_t w_nextState;
  logic   w_startFrame;
  logic   w_shiftBit;
  logic   w_frameGood;
  logic   w_frameBad;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_csSync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_SPI_CS),
    .o_sync  (w_csSync),
    .o_rise  (w_csRise),
    .o_fall  (w_csFall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_clkSync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_SPI_clock),
    .o_sync  (w_clkSync),
    .o_rise  (w_clkRise),
    .o_fall  (w_clkFall)
  );

  // Only the falling edge of the SPI clock matters here.
  assign w_unusedClk = w_clkSync & w_clkRise;

  // Data needs no edge detection, just the plain synchronizer chain.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_dataSync <= '1;
    end else begin
      r_dataSync[0] <= i_SPI_data;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_dataSync[k] <= r_dataSync[k-1];
      end
    end
  end

  assign w_dataSync = r_dataSync[SYNC_STAGES-1];

  // The synchronizers come out of reset holding stale idle levels. Hold off
  // the WAIT_IDLE exit until the chains and edge pulses have flushed, so a
  // chip select that was already low at reset release is not mistaken for
  // an idle bus.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_settle <= '0;
    end else if (r_settle != SETTLE_CYCLES) begin
      r_settle <= r_settle + BIT_CNT_W'(1);
    end
  end

  assign w_settled = (r_settle == SETTLE_CYCLES);

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= WAIT_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath strobes. A CS rising edge takes priority over a
  // clock falling edge in the same cycle, so that last edge is not counted.
  always_comb begin
    w_nextState  = r_state;
    w_startFrame = 1'b0;
    w_shiftBit   = 1'b0;
    w_frameGood  = 1'b0;
    w_frameBad   = 1'b0;
    case (r_state)
      WAIT_IDLE: begin
        if (w_settled && w_csSync) begin
          w_nextState = IDLE;
        end
      end
      IDLE: begin
        if (w_csFall) begin
          w_startFrame = 1'b1;
          w_nextState  = RECEIVE;
        end
      end
      RECEIVE: begin
        if (w_csRise) begin
          if (r_bitCnt == FRAME_CNT) begin
            w_frameGood = 1'b1;
          end else begin
            w_frameBad = 1'b1;
          end
          w_nextState = IDLE;
        end else if (w_clkFall) begin
          w_shiftBit = 1'b1;
        end
      end
      default: begin
        w_nextState = WAIT_IDLE;
      end
    endcase
  end

  // Shift register, saturating bit counter, output register and the two
  // result pulses. The counter saturates so an overlong frame can never wrap
  // back to a count that looks correct.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift      <= '0;
      r_bitCnt     <= '0;
      r_data       <= '0;
      r_dataValid  <= 1'b0;
      r_frameError <= 1'b0;
    end else begin
      r_dataValid  <= w_frameGood;
      r_frameError <= w_frameBad;
      if (w_frameGood) begin
        r_data <= r_shift;
      end
      if (w_startFrame) begin
        r_shift  <= '0;
        r_bitCnt <= '0;
      end else if (w_shiftBit) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], w_dataSync};
        if (r_bitCnt != BIT_CNT_MAX) begin
          r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
        end
      end
    end
  end

  assign o_data        = r_data;
  assign o_data_valid  = r_dataValid;
  assign o_frame_error = r_frameError;

endmodule
